// File: rtl/process_scheduler.sv
// Preemptive round-robin context scheduler: keeps a saved PC/SP per slot, times the
// running slice, freezes the core on expiry, saves its context and loads the next valid slot.
module process_scheduler #(
    parameter  int NUM_PROC  = 4,
    parameter  int PC_W      = 16,
    parameter  int DATA_W    = 32,
    parameter  int QUANTUM_W = 16,
    localparam int IDX_W     = $clog2(NUM_PROC)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [QUANTUM_W-1:0] quantum,
    input  logic [PC_W-1:0]      core_pc,
    input  logic [DATA_W-1:0]    core_sp,
    input  logic                 core_stall,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [PC_W-1:0]      cfg_pc,
    input  logic [DATA_W-1:0]    cfg_sp,
    input  logic                 cfg_valid,
    output logic                 preempt,
    output logic                 load_ctx,
    output logic [PC_W-1:0]      new_pc,
    output logic [DATA_W-1:0]    new_sp,
    output logic [IDX_W-1:0]     cur_proc,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_DRAIN  = 3'd2,
        S_SAVE   = 3'd3,
        S_SELECT = 3'd4,
        S_LOAD   = 3'd5
    } state_t;

    localparam logic [QUANTUM_W-1:0] Q_ZERO = {QUANTUM_W{1'b0}};
    localparam logic [QUANTUM_W-1:0] Q_ONE  = {{(QUANTUM_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]     LAST_SLOT = IDX_W'(NUM_PROC - 1);

    state_t                state_q, state_d;
    logic [QUANTUM_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]      cur_q, cur_d;
    logic [IDX_W-1:0]      next_q, next_d;
    logic [NUM_PROC-1:0]   valid_q, valid_d;
    logic [PC_W-1:0]       tbl_pc_q [NUM_PROC];
    logic [PC_W-1:0]       tbl_pc_d [NUM_PROC];
    logic [DATA_W-1:0]     tbl_sp_q [NUM_PROC];
    logic [DATA_W-1:0]     tbl_sp_d [NUM_PROC];
    logic                  preempt_q, preempt_d;
    logic                  load_ctx_q, load_ctx_d;
    logic                  busy_q, busy_d;
    logic [PC_W-1:0]       new_pc_q, new_pc_d;
    logic [DATA_W-1:0]     new_sp_q, new_sp_d;
    logic [IDX_W-1:0]      sel_idx, cand_idx;

    // Next-state, slot search, table update and output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cur_d    = cur_q;
        next_d   = next_q;
        valid_d  = valid_q;
        tbl_pc_d = tbl_pc_q;
        tbl_sp_d = tbl_sp_q;
        new_pc_d = new_pc_q;
        new_sp_d = new_sp_q;

        // Scan from the farthest slot back so the nearest valid one after cur_q wins;
        // cur_q itself (offset NUM_PROC) is the last resort.
        sel_idx  = cur_q;
        cand_idx = cur_q;
        for (int i = NUM_PROC; i >= 1; i--) begin
            cand_idx = cur_q + IDX_W'(i);
            sel_idx  = valid_q[cand_idx] ? cand_idx : sel_idx;
        end

        case (state_q)
            S_IDLE: begin
                if (enable && (|valid_q)) begin
                    state_d = S_SELECT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (enable && (quantum != Q_ZERO)) begin
                    if (cnt_q >= (quantum - Q_ONE)) begin
                        state_d = S_DRAIN;
                        cnt_d   = Q_ZERO;
                    end else begin
                        cnt_d   = cnt_q + Q_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_DRAIN: begin
                state_d = core_stall ? S_DRAIN : S_SAVE;
            end
            S_SAVE: begin
                tbl_pc_d[cur_q] = core_pc;
                tbl_sp_d[cur_q] = core_sp;
                state_d         = S_SELECT;
            end
            S_SELECT: begin
                if (|valid_q) begin
                    next_d  = sel_idx;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                cur_d   = next_q;
                cnt_d   = Q_ZERO;
                state_d = S_RUN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Applied after SAVE so a same-cycle config write to the same slot takes priority.
        if (cfg_we) begin
            tbl_pc_d[cfg_idx] = cfg_pc;
            tbl_sp_d[cfg_idx] = cfg_sp;
            valid_d[cfg_idx]  = cfg_valid;
        end else begin
            valid_d = valid_q;
        end

        if (state_d == S_LOAD) begin
            new_pc_d = tbl_pc_d[next_d];
            new_sp_d = tbl_sp_d[next_d];
        end else begin
            new_pc_d = new_pc_q;
            new_sp_d = new_sp_q;
        end

        preempt_d  = (state_d == S_DRAIN) || (state_d == S_SAVE) ||
                     (state_d == S_SELECT) || (state_d == S_LOAD);
        busy_d     = preempt_d;
        load_ctx_d = (state_d == S_LOAD);
    end

    // State, table and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= Q_ZERO;
            cur_q      <= LAST_SLOT;
            next_q     <= {IDX_W{1'b0}};
            valid_q    <= {NUM_PROC{1'b0}};
            for (int i = 0; i < NUM_PROC; i++) begin
                tbl_pc_q[i] <= {PC_W{1'b0}};
                tbl_sp_q[i] <= {DATA_W{1'b0}};
            end
            preempt_q  <= 1'b0;
            load_ctx_q <= 1'b0;
            busy_q     <= 1'b0;
            new_pc_q   <= {PC_W{1'b0}};
            new_sp_q   <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            next_q     <= next_d;
            valid_q    <= valid_d;
            tbl_pc_q   <= tbl_pc_d;
            tbl_sp_q   <= tbl_sp_d;
            preempt_q  <= preempt_d;
            load_ctx_q <= load_ctx_d;
            busy_q     <= busy_d;
            new_pc_q   <= new_pc_d;
            new_sp_q   <= new_sp_d;
        end
    end

    assign preempt  = preempt_q;
    assign load_ctx = load_ctx_q;
    assign busy     = busy_q;
    assign new_pc   = new_pc_q;
    assign new_sp   = new_sp_q;
    assign cur_proc = cur_q;

endmodule

// File: tb/tb_process_scheduler.sv
// Directed bench for process_scheduler: outputs sampled and inputs driven on the falling edge.
module tb_process_scheduler;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] quantum;
    logic [15:0] core_pc;
    logic [31:0] core_sp;
    logic        core_stall;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [15:0] cfg_pc;
    logic [31:0] cfg_sp;
    logic        cfg_valid;
    logic        preempt;
    logic        load_ctx;
    logic [15:0] new_pc;
    logic [31:0] new_sp;
    logic [1:0]  cur_proc;
    logic        busy;

    int total;
    int bad;

    process_scheduler #(
        .NUM_PROC(4), .PC_W(16), .DATA_W(32), .QUANTUM_W(16)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .quantum(quantum),
        .core_pc(core_pc), .core_sp(core_sp), .core_stall(core_stall),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pc(cfg_pc), .cfg_sp(cfg_sp),
        .cfg_valid(cfg_valid), .preempt(preempt), .load_ctx(load_ctx),
        .new_pc(new_pc), .new_sp(new_sp), .cur_proc(cur_proc), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Each call checks the current RUN cycle is quiet, then advances one cycle.
    task automatic run_quiet(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            chk({tag, "_preempt"}, 64'(preempt), 64'd0);
            chk({tag, "_busy"}, 64'(busy), 64'd0);
            tick();
        end
    endtask

    // Entered at the first DRAIN cycle with no stall; returns at the first RUN cycle.
    task automatic expect_switch(input string tag, input logic [15:0] epc,
                                 input logic [31:0] esp, input logic [1:0] ecur);
        chk({tag, "_drain_pre"}, 64'(preempt), 64'd1);
        chk({tag, "_drain_busy"}, 64'(busy), 64'd1);
        chk({tag, "_drain_ld"}, 64'(load_ctx), 64'd0);
        tick();
        chk({tag, "_save_pre"}, 64'(preempt), 64'd1);
        chk({tag, "_save_ld"}, 64'(load_ctx), 64'd0);
        tick();
        chk({tag, "_sel_pre"}, 64'(preempt), 64'd1);
        chk({tag, "_sel_ld"}, 64'(load_ctx), 64'd0);
        tick();
        chk({tag, "_load_pre"}, 64'(preempt), 64'd1);
        chk({tag, "_load_ld"}, 64'(load_ctx), 64'd1);
        chk({tag, "_new_pc"}, 64'(new_pc), 64'(epc));
        chk({tag, "_new_sp"}, 64'(new_sp), 64'(esp));
        tick();
        chk({tag, "_run_ld"}, 64'(load_ctx), 64'd0);
        chk({tag, "_run_pre"}, 64'(preempt), 64'd0);
        chk({tag, "_run_cur"}, 64'(cur_proc), 64'(ecur));
        chk({tag, "_hold_pc"}, 64'(new_pc), 64'(epc));
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1; enable = 1'b0; quantum = 16'd0;
        core_pc = 16'd0; core_sp = 32'd0; core_stall = 1'b0;
        cfg_we = 1'b0; cfg_idx = 2'd0; cfg_pc = 16'd0; cfg_sp = 32'd0; cfg_valid = 1'b0;

        tick();
        chk("rst_preempt", 64'(preempt), 64'd0);
        chk("rst_load", 64'(load_ctx), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cur", 64'(cur_proc), 64'd3);
        chk("rst_pc", 64'(new_pc), 64'd0);
        chk("rst_sp", 64'(new_sp), 64'd0);

        // Test 1: two slots, quantum 8
        reset = 1'b0;
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_pc = 16'd10; cfg_sp = 32'd200; cfg_valid = 1'b1;
        tick();
        cfg_idx = 2'd1; cfg_pc = 16'd50; cfg_sp = 32'd300;
        tick();
        cfg_we = 1'b0; quantum = 16'd8; enable = 1'b1;
        chk("idle_busy", 64'(busy), 64'd0);
        tick();
        chk("first_sel_pre", 64'(preempt), 64'd1);
        chk("first_sel_ld", 64'(load_ctx), 64'd0);
        tick();
        chk("first_ld", 64'(load_ctx), 64'd1);
        chk("first_pc", 64'(new_pc), 64'd10);
        chk("first_sp", 64'(new_sp), 64'd200);
        chk("first_cur_before", 64'(cur_proc), 64'd3);
        tick();
        chk("first_cur", 64'(cur_proc), 64'd0);
        chk("first_run_ld", 64'(load_ctx), 64'd0);
        core_pc = 16'd23; core_sp = 32'd198;
        run_quiet("t1_run", 8);
        expect_switch("t1_sw", 16'd50, 32'd300, 2'd1);

        // Test 2: slot0 comes back with its saved context
        core_pc = 16'd60; core_sp = 32'd310;
        run_quiet("t2_run", 8);
        expect_switch("t2_sw", 16'd23, 32'd198, 2'd0);
        core_pc = 16'd24; core_sp = 32'd197;
        run_quiet("t2b_run", 8);
        expect_switch("t2b_sw", 16'd60, 32'd310, 2'd1);

        // Test 3: stall holds DRAIN; saved context is the post-stall one
        run_quiet("t3_run", 8);
        core_stall = 1'b1; core_pc = 16'd99; core_sp = 32'd999;
        for (int k = 0; k < 5; k++) begin
            chk("t3_stall_pre", 64'(preempt), 64'd1);
            chk("t3_stall_ld", 64'(load_ctx), 64'd0);
            tick();
        end
        core_stall = 1'b0; core_pc = 16'd77; core_sp = 32'd400;
        expect_switch("t3_sw", 16'd24, 32'd197, 2'd0);
        core_pc = 16'd30; core_sp = 32'd190;
        run_quiet("t3b_run", 8);
        expect_switch("t3b_sw", 16'd77, 32'd400, 2'd1);

        // Test 4: only slot2 valid, quantum 3; running slot1 is invalidated under it
        quantum = 16'd0;
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_valid = 1'b0;
        run_quiet("t4_cfg0", 1);
        cfg_idx = 2'd1;
        run_quiet("t4_cfg1", 1);
        cfg_idx = 2'd2; cfg_pc = 16'd5; cfg_sp = 32'd500; cfg_valid = 1'b1;
        run_quiet("t4_cfg2", 1);
        cfg_we = 1'b0; quantum = 16'd3; core_pc = 16'd41; core_sp = 32'd410;
        run_quiet("t4_run", 3);
        expect_switch("t4_sw", 16'd5, 32'd500, 2'd2);
        core_pc = 16'd6; core_sp = 32'd501;
        run_quiet("t4b_run", 3);
        expect_switch("t4b_sw", 16'd6, 32'd501, 2'd2);
        core_pc = 16'd8; core_sp = 32'd502;
        run_quiet("t4c_run", 3);
        expect_switch("t4c_sw", 16'd8, 32'd502, 2'd2);

        // Test 5: quantum 0 and enable 0 never preempt; enable dropped mid-switch
        quantum = 16'd0;
        run_quiet("t5_q0", 100);
        enable = 1'b0; quantum = 16'd3;
        run_quiet("t5_en0", 50);
        enable = 1'b1; quantum = 16'd4; core_pc = 16'd9; core_sp = 32'd503;
        run_quiet("t5_run", 4);
        enable = 1'b0;
        expect_switch("t5_sw", 16'd9, 32'd503, 2'd2);
        run_quiet("t5_frozen", 20);

        // Test 6: reset during SELECT
        enable = 1'b1;
        run_quiet("t6_run", 4);
        chk("t6_drain", 64'(preempt), 64'd1);
        tick();
        chk("t6_save", 64'(preempt), 64'd1);
        tick();
        chk("t6_sel", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        chk("t6_rst_pre", 64'(preempt), 64'd0);
        chk("t6_rst_ld", 64'(load_ctx), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_cur", 64'(cur_proc), 64'd3);
        chk("t6_rst_pc", 64'(new_pc), 64'd0);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t6_novalid_busy", 64'(busy), 64'd0);
            chk("t6_novalid_pre", 64'(preempt), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
